dr_load_sequencer: RTL and testbench

- Controller that fills the 32-bit data register from byte-wide synchronous memory.
- Issues byte addresses, then drives the register's enable and 2-bit function select for each byte.
- Produces signed/unsigned byte loads and big/little-endian word loads.
- Sits between the control unit (Start/Mode/BaseAddr handshake) and the memory + data register pair.

---
 rtl/dr_load_sequencer_pkg.sv | 41 ++++
 rtl/dr_load_sequencer.sv | 106 ++++++++++
 tb/tb_dr_load_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dr_load_sequencer_pkg.sv
// Shared encodings for the data-register load sequencer: load modes,
// data-register function codes and controller states.
package dr_load_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_BYTE_S  = 2'b00,
    MODE_BYTE_U  = 2'b01,
    MODE_WORD_BE = 2'b10,
    MODE_WORD_LE = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    DR_SEXT = 2'b00,
    DR_ZEXT = 2'b01,
    DR_SHL  = 2'b10,
    DR_SHR  = 2'b11
  } dr_fun_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Word modes move four bytes; byte modes move one.
  function automatic logic is_word(input mode_t mode);
    return (mode == MODE_WORD_BE) || (mode == MODE_WORD_LE);
  endfunction

  // Register function for byte number idx of a load in the given mode.
  function automatic dr_fun_t fun_for(input mode_t mode, input logic [1:0] idx);
    case (mode)
      MODE_BYTE_S:  return DR_SEXT;
      MODE_BYTE_U:  return DR_ZEXT;
      MODE_WORD_BE: return (idx == 2'd0) ? DR_ZEXT : DR_SHL;
      default:      return DR_SHR;
    endcase
  endfunction

endpackage

// File: rtl/dr_load_sequencer.sv
// Sequences byte reads from synchronous memory into the 32-bit data register,
// building signed/unsigned byte loads and big/little-endian word loads.
module dr_load_sequencer
  import dr_load_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Mode,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic              Abort,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              DR_E,
  output logic [1:0]        DR_FunSel,
  output logic              Busy,
  output logic              Done
);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        idx_q, idx_d;
  logic              last_byte;
  logic [ADDR_W-1:0] cur_addr;

  assign last_byte = is_word(mode_q) ? (idx_q == 2'd3) : 1'b1;
  // Wraps naturally modulo 2^ADDR_W.
  assign cur_addr  = base_q + ADDR_W'(idx_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BYTE_S;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    base_d    = base_q;
    idx_d     = idx_q;
    MemAddr   = '0;
    MemRead   = 1'b0;
    DR_E      = 1'b0;
    DR_FunSel = DR_SEXT;
    Busy      = 1'b0;
    Done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          mode_d  = mode_t'(Mode);
          base_d  = BaseAddr;
          idx_d   = 2'd0;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        Busy    = 1'b1;
        MemRead = 1'b1;
        MemAddr = cur_addr;
        state_d = Abort ? ST_IDLE : ST_WRITE;
      end

      ST_WRITE: begin
        Busy      = 1'b1;
        DR_E      = 1'b1;
        MemAddr   = cur_addr;
        DR_FunSel = fun_for(mode_q, idx_q);
        // Abort outranks completion: the byte still lands, but no Done.
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (last_byte) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_READ;
        end
      end

      ST_DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dr_load_sequencer.sv
// Self-checking bench: byte memory and data register models around the
// sequencer, with cycle-by-cycle output traces and final register values.
module tb_dr_load_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Mode = 2'b00;
  logic [15:0] BaseAddr = 16'h0000;
  logic        Abort = 1'b0;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic        DR_E;
  logic [1:0]  DR_FunSel;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  rdata = 8'h00;
  logic [31:0] dreg = 32'h0;

  dr_load_sequencer #(.ADDR_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode),
    .BaseAddr(BaseAddr), .Abort(Abort), .MemAddr(MemAddr), .MemRead(MemRead),
    .DR_E(DR_E), .DR_FunSel(DR_FunSel), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Synchronous byte memory and the data register the sequencer steers.
  always @(posedge Clock) begin
    if (MemRead) rdata <= mem[MemAddr];
    if (DR_E) begin
      case (DR_FunSel)
        2'b00: dreg <= {{24{rdata[7]}}, rdata};
        2'b01: dreg <= {24'h0, rdata};
        2'b10: dreg <= {dreg[23:0], rdata};
        default: dreg <= {rdata, dreg[31:8]};
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [21:0] outs();
    return {Busy, Done, MemRead, DR_E, DR_FunSel, MemAddr};
  endfunction

  // Expected {Busy,Done,MemRead,DR_E,FunSel,MemAddr} in cycle cyc after the
  // Start edge; the run ends after cycle stop (abort) or after Done.
  function automatic logic [21:0] exp_out(input logic [1:0] m, input logic [15:0] b,
                                          input int cyc, input int stop);
    int n;
    int k;
    logic [15:0] a;
    logic [1:0] fs;
    n = m[1] ? 4 : 1;
    if (cyc < 1 || cyc > stop) return '0;
    if (cyc == 2 * n + 1) return {4'b1100, 2'b00, 16'h0};
    k = (cyc - 1) / 2;
    a = b + 16'(k);
    if (cyc % 2 == 1) return {4'b1010, 2'b00, a};
    case (m)
      2'd0: fs = 2'd0;
      2'd1: fs = 2'd1;
      2'd2: fs = (k == 0) ? 2'd1 : 2'd2;
      default: fs = 2'd3;
    endcase
    return {4'b1001, fs, a};
  endfunction

  // Register value a completed load must produce, from the memory contents.
  function automatic logic [31:0] exp_reg(input logic [1:0] m, input logic [15:0] b);
    logic [31:0] v0, v1, v2, v3;
    v0 = 32'(mem[b]);
    v1 = 32'(mem[16'(b + 16'd1)]);
    v2 = 32'(mem[16'(b + 16'd2)]);
    v3 = 32'(mem[16'(b + 16'd3)]);
    case (m)
      2'd0: return (v0 >= 32'd128) ? v0 - 32'd256 : v0;
      2'd1: return v0;
      2'd2: return v0 * 32'h0100_0000 + v1 * 32'h1_0000 + v2 * 32'h100 + v3;
      default: return v3 * 32'h0100_0000 + v2 * 32'h1_0000 + v1 * 32'h100 + v0;
    endcase
  endfunction

  // ab/rs: cycle in which Abort / a second Start is raised (0 = never).
  task automatic run_op(input string name, input logic [1:0] m, input logic [15:0] b,
                        input int ab, input int rs, input bit chk_reg, input logic [31:0] want);
    int n;
    int stop;
    n = m[1] ? 4 : 1;
    stop = (ab >= 1 && ab <= 2 * n) ? ab : 2 * n + 1;
    @(negedge Clock);
    Start = 1'b1; Mode = m; BaseAddr = b; Abort = 1'b0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge Clock);
      check($sformatf("%s cyc%0d outs", name, cyc), 32'(outs()), 32'(exp_out(m, b, cyc, stop)));
      Start = (cyc == rs);
      if (cyc == rs) begin
        Mode = ~m;
        BaseAddr = b ^ 16'h5555;
      end
      Abort = (cyc == ab);
    end
    Start = 1'b0; Abort = 1'b0;
    if (chk_reg) check($sformatf("%s reg", name), dreg, want);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [15:0] base;
    int          abort_cyc;
    int          restart_cyc;
    bit          chk_reg;
    logic [31:0] reg_val;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [1:0] m;
    logic [15:0] b;
    int ab;
    int n;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h80;
    mem[16'h0020] = 8'h12; mem[16'h0021] = 8'h34;
    mem[16'h0022] = 8'h56; mem[16'h0023] = 8'h78;
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB;
    mem[16'h0000] = 8'hCC; mem[16'h0001] = 8'hDD;

    vecs.push_back('{"byte_s",       2'd0, 16'h0010, 0, 0, 1'b1, 32'hFFFF_FF80});
    vecs.push_back('{"byte_u",       2'd1, 16'h0010, 0, 0, 1'b1, 32'h0000_0080});
    vecs.push_back('{"word_be",      2'd2, 16'h0020, 0, 0, 1'b1, 32'h1234_5678});
    vecs.push_back('{"word_le",      2'd3, 16'h0020, 0, 0, 1'b1, 32'h7856_3412});
    vecs.push_back('{"wrap_be",      2'd2, 16'hFFFE, 0, 0, 1'b1, 32'hAABB_CCDD});
    vecs.push_back('{"wrap_le",      2'd3, 16'hFFFE, 0, 0, 1'b1, 32'hDDCC_BBAA});
    vecs.push_back('{"abort_w1",     2'd2, 16'h0020, 4, 3, 1'b1, 32'h0000_1234});
    vecs.push_back('{"after_abort",  2'd2, 16'h0020, 0, 0, 1'b1, 32'h1234_5678});
    vecs.push_back('{"abort_last",   2'd0, 16'h0010, 2, 0, 1'b1, 32'hFFFF_FF80});
    vecs.push_back('{"abort_done",   2'd1, 16'h0020, 3, 0, 1'b1, 32'h0000_0012});
    vecs.push_back('{"start_done",   2'd0, 16'h0023, 0, 3, 1'b1, 32'h0000_0078});
    vecs.push_back('{"abort_read",   2'd3, 16'h0020, 5, 0, 1'b1, 32'h3412_0000});

    Reset = 1'b0;
    #1 Reset = 1'b1;
    #1 check("reset outs", 32'(outs()), 32'h0);
    #20;
    @(negedge Clock) Reset = 1'b0;
    @(negedge Clock) check("post reset outs", 32'(outs()), 32'h0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].mode, vecs[i].base, vecs[i].abort_cyc,
             vecs[i].restart_cyc, vecs[i].chk_reg, vecs[i].reg_val);

    // Asynchronous reset in the middle of a READ.
    @(negedge Clock);
    Start = 1'b1; Mode = 2'd2; BaseAddr = 16'h0020;
    @(negedge Clock);
    Start = 1'b0;
    check("pre reset read", 32'(outs()), 32'(exp_out(2'd2, 16'h0020, 1, 9)));
    #2 Reset = 1'b1;
    #1 check("async reset outs", 32'(outs()), 32'h0);
    @(negedge Clock) Reset = 1'b0;
    @(negedge Clock) check("reset release idle", 32'(outs()), 32'h0);
    @(negedge Clock) check("reset release idle2", 32'(outs()), 32'h0);
    run_op("after_reset", 2'd3, 16'h0020, 0, 0, 1'b1, 32'h7856_3412);

    // Randomized loads, some aborted, against the register model.
    for (int t = 0; t < 25; t++) begin
      m = 2'($urandom_range(0, 3));
      b = 16'($urandom);
      for (int k = 0; k < 4; k++) mem[16'(b + 16'(k))] = 8'($urandom);
      n = m[1] ? 4 : 1;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * n)) : 0;
      run_op($sformatf("rand%0d", t), m, b, ab, 0, (ab == 0), exp_reg(m, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
